// File: rtl/mem_request_pipe.sv
// In-order memory request stage: request FIFO, word array and fixed-latency response pipe.
// Define MEM_STALL_INJECT_EN to add LFSR-driven pseudo-random issue suppression.
module mem_request_pipe #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  input  logic        rw_in,
  input  logic [3:0]  id_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic [3:0]  id_out,
  output logic        ready_out,
  output logic        stall_out,
  output logic        idle_out
);

  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned BusyW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int unsigned Words = 2 ** ADDR_BITS;

  logic [ADDR_BITS-1:0] r_q_idx  [DEPTH];
  logic [31:0]          r_q_data [DEPTH];
  logic                 r_q_rw   [DEPTH];
  logic [3:0]           r_q_id   [DEPTH];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [BusyW-1:0]     r_busy;
  logic [31:0]          r_mem    [Words];
  logic                 r_pv     [LATENCY];
  logic [31:0]          r_pd     [LATENCY];
  logic [3:0]           r_pi     [LATENCY];

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue_ok;
  logic                 w_any_valid;
  logic [ADDR_BITS-1:0] w_in_idx;
  logic [ADDR_BITS-1:0] w_head_idx;
  logic                 w_head_rw;
  logic [31:0]          w_issue_data;
  logic                 w_unused_addr;

  assign w_in_idx      = addr_in[ADDR_BITS+1:2];
  assign w_unused_addr = ^{addr_in[31:ADDR_BITS+2], addr_in[1:0]};

`ifdef MEM_STALL_INJECT_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 8'hA5;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_issue_ok = (r_lfsr[1:0] != 2'b11);
`else
  assign w_issue_ok = 1'b1;
`endif

  assign w_full       = (r_count == CntW'(DEPTH));
  assign w_push       = valid_in && !w_full;
  assign w_pop        = (r_count != '0) && (r_busy == '0) && w_issue_ok;
  assign w_head_idx   = r_q_idx[r_rd_ptr];
  assign w_head_rw    = r_q_rw[r_rd_ptr];
  assign w_issue_data = w_head_rw ? r_q_data[r_rd_ptr] : r_mem[w_head_idx];

  // FIFO payload needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_idx[r_wr_ptr]  <= w_in_idx;
      r_q_data[r_wr_ptr] <= data_in;
      r_q_rw[r_wr_ptr]   <= rw_in;
      r_q_id[r_wr_ptr]   <= id_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop && w_head_rw) r_busy <= BusyW'(WR_CYCLES - 1);
      else if (r_busy != '0)  r_busy <= r_busy - BusyW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Words; i++) r_mem[i] <= '0;
    end else if (w_pop && w_head_rw) begin
      r_mem[w_head_idx] <= r_q_data[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
        r_pi[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_pop;
      r_pd[0] <= w_pop ? w_issue_data : 32'd0;
      r_pi[0] <= w_pop ? r_q_id[r_rd_ptr] : 4'd0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pd[i] <= r_pd[i-1];
        r_pi[i] <= r_pi[i-1];
      end
    end
  end

  always_comb begin
    w_any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) w_any_valid = w_any_valid | r_pv[i];
  end

  assign ready_out = r_pv[LATENCY-1];
  assign data_out  = r_pd[LATENCY-1];
  assign id_out    = r_pi[LATENCY-1];
  assign stall_out = w_full;
  assign idle_out  = (r_count == '0) && !w_any_valid && (r_busy == '0);

endmodule

// File: tb/tb_mem_request_pipe.sv
// Scoreboard bench for mem_request_pipe: expectations queued at accept, checked at response.
module tb_mem_request_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        rw_in;
  logic [3:0]  id_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic [3:0]  id_out;
  logic        ready_out;
  logic        stall_out;
  logic        idle_out;

  mem_request_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .rw_in     (rw_in),
    .id_in     (id_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .id_out    (id_out),
    .ready_out (ready_out),
    .stall_out (stall_out),
    .idle_out  (idle_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } exp_t;

  localparam int HistN = 4096;

  exp_t        sb_q[$];
  logic [31:0] model_mem [1024];
  logic        stall_hist [HistN];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_resp = 0;
  int          last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // cyc-1 is the index of the edge just taken
  always @(negedge clk) begin
    if (cyc > 0 && cyc <= HistN) stall_hist[cyc-1] = stall_out;
    if (!rst && ready_out) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 32'(ready_out), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_id", {28'd0, id_out}, {28'd0, e.id});
        check("resp_data", data_out, e.data);
        n_resp++;
      end
    end
  end

  task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] id);
    int   g = 0;
    exp_t e;
    @(negedge clk);
    addr_in = a; data_in = d; rw_in = rw; id_in = id; valid_in = 1'b1;
    while (stall_out && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("stall_timeout", 32'd1, 32'd0);
    e.id   = id;
    e.data = rw ? d : model_mem[a[11:2]];
    if (rw) model_mem[a[11:2]] = d;
    sb_q.push_back(e);
    @(posedge clk);
    last_acc = cyc;
    #1 valid_in = 1'b0;
  endtask

  task automatic sample_ready(input int n, output logic [7:0] pat);
    pat = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pat[k] = ready_out;
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((sb_q.size() != 0 || !idle_out) && g < 500) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_drain"}, sb_q.size(), 32'd0);
    check({tag, "_idle"}, 32'(idle_out), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         acc [8];
    int         base;
    addr_in = '0; data_in = '0; rw_in = 1'b0; id_in = '0; valid_in = 1'b0;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    #2 rst = 1'b1;
    #1;
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_id", {28'd0, id_out}, 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_idle", 32'(idle_out), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single load: response exactly one cycle, two edges after accept
    send(1'b0, 32'h0000_0010, 32'd0, 4'd3);
    check("t1_busy_after_accept", 32'(idle_out), 32'd0);
    sample_ready(4, pat);
`ifndef MEM_STALL_INJECT_EN
    check("t1_ready_timing", {24'd0, pat}, 32'h0000_0004);
`endif
    drain("t1");

    // Store then dependent load; store holds the port one extra cycle
    send(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'd1);
    send(1'b0, 32'h0000_0020, 32'd0, 4'd2);
    sample_ready(5, pat);
`ifndef MEM_STALL_INJECT_EN
    check("t2_ready_timing", {24'd0, pat}, 32'h0000_000A);
`endif
    drain("t2");

    // Eight back-to-back stores fill the FIFO
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(8 + i));
      acc[i] = last_acc;
    end
    drain("t3");
`ifndef MEM_STALL_INJECT_EN
    base = acc[0];
    check("t3_stall_before", 32'(stall_hist[base+5]), 32'd0);
    check("t3_stall_rise", 32'(stall_hist[base+6]), 32'd1);
    check("t3_held_accept", 32'(acc[7] - base), 32'd8);
`endif

    // Upper address bits alias onto the same word
    send(1'b1, 32'h0000_0040, 32'h0000_0055, 4'd5);
    send(1'b0, 32'h1000_0040, 32'd0, 4'd6);
    drain("t4");
    check("t4_alias_model", model_mem[10'h10], 32'h0000_0055);

    // Reset with three requests in flight
    send(1'b1, 32'h0000_0080, 32'h0000_0077, 4'd4);
    send(1'b0, 32'h0000_0080, 32'd0, 4'd5);
    send(1'b0, 32'h0000_0084, 32'd0, 4'd6);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(ready_out), 32'd0);
    check("t5_rst_data", data_out, 32'd0);
    check("t5_rst_id", {28'd0, id_out}, 32'd0);
    check("t5_rst_idle", 32'(idle_out), 32'd1);
    sb_q.delete();
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sample_ready(6, pat);
    check("t5_no_late_ready", {24'd0, pat}, 32'd0);
    send(1'b0, 32'h0000_0080, 32'd0, 4'd7);
    drain("t5");

    // Streamed loads over random words with random upper bits
    for (int i = 0; i < 16; i++) begin
      send(1'b1, ($urandom_range(0, 1023) << 2) | 32'($urandom_range(0, 7) << 20),
           $urandom, 4'(i));
    end
    drain("t6a");
    n_resp = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, ($urandom_range(0, 1023) << 2) | 32'($urandom_range(0, 7) << 24),
           32'd0, 4'(i));
    end
    drain("t6");
    check("t6_resp_count", n_resp, 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_request_pipe.md
Name: mem_request_pipe

Overview:
- Backing data-memory stage directly downstream of the load/store queue; implements the cache team's memory_system request/response contract.
- Buffers requests in an in-order FIFO, performs each one on an internal word array, and returns each result after a fixed pipeline latency.
- Stores hold the array port for several cycles, which creates back-pressure (stall_out) that the LSQ and core must honour.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, >=2.
- LATENCY, 2, issue-to-response pipeline stages; >=1.
- ADDR_BITS, 10, word-index width; array holds 2**ADDR_BITS 32-bit words.
- WR_CYCLES, 2, cycles a store occupies the array port; >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- addr_in  in  32  byte address; word index = addr_in[ADDR_BITS+1:2]; other bits ignored (aliasing).
- data_in  in  32  store data.
- rw_in  in  1  1 = store, 0 = load.
- id_in  in  4  LSQ entry id.
- valid_in  in  1  request present this cycle.
- data_out  out  32  load data, or echoed store data.
- id_out  out  4  id of the request being completed.
- ready_out  out  1  data_out/id_out valid this cycle.
- stall_out  out  1  FIFO full; request is not accepted.
- idle_out  out  1  FIFO empty, pipeline empty, port not busy.

Behaviour:
- Reset (async, any time, mid-operation included):
  - Clears FIFO pointers/count, pipeline valids, port-busy counter and every array word.
  - Outputs: data_out=0, id_out=0, ready_out=0, stall_out=0, idle_out=1.
  - In-flight requests are discarded; no response is produced for them.
- Accept:
  - At an edge with valid_in=1 and stall_out=0, push {addr, data, rw, id}.
  - valid_in while stall_out=1 is ignored; the requester must hold the request and retry.
- stall_out = (count == DEPTH), combinational from registered count.
  - No push when full, even if a pop happens at the same edge.
- Issue: at an edge where FIFO is non-empty and the port-busy counter is 0, pop the head.
  - Load: read array[index] at issue; write that word into pipeline stage 0.
  - Store: write array[index] <= data at issue; stage 0 data = store data; port-busy counter <= WR_CYCLES-1, decremented each edge, blocking issue while non-zero.
  - Simultaneous push and pop when not full is allowed; count stays unchanged.
  - No bypass: a request accepted at edge t issues at edge t+1 at earliest.
- Pipeline: LATENCY stages of {valid, data, id}, shifted every edge.
  - Bubbles carry valid=0, data=0, id=0.
  - ready_out/data_out/id_out are the last stage directly.
  - An unimpeded request accepted at edge t gives ready_out=1 for exactly the cycle after edge t+LATENCY.
- Ordering: strictly in order, so a load issued after a store to the same word returns the new data.
- Throughput: max one issue per cycle for loads, one per WR_CYCLES for stores.
- idle_out = (count==0) && no stage valid && busy counter==0.

Optional Feature:
- MEM_STALL_INJECT_EN defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seeded 8'hA5 on reset, advancing every edge.
  - Issue is suppressed in any cycle where lfsr[1:0]==2'b11; this exercises the stall paths of the LSQ and core.
- Not defined: no LFSR, no suppression; timing exactly as above.

Test Plan:
- After reset, load addr 0x0000_0010 id 3 accepted at edge 0 -> ready_out=1 after edge 2, data_out=0, id_out=3, one cycle only.
- Store 0xDEADBEEF to 0x20 id 1, then load 0x20 id 2 next cycle -> responses id 1 (data 0xDEADBEEF), then id 2 (data 0xDEADBEEF) two cycles later (store occupies port).
- Eight back-to-back stores, DEPTH=4, WR_CYCLES=2, starting edge 0 -> stall_out rises after edge 6; 8th store is held until stall_out drops; all 8 ids respond in order.
- Load to 0x1000_0040 after storing 0x55 to 0x40 -> data_out=0x55 (upper bits alias).
- Assert rst while 3 requests are in flight -> outputs zero immediately, idle_out=1, no later ready_out; subsequent load of a previously stored address returns 0.
- With MEM_STALL_INJECT_EN: 16 loads streamed -> responses stay in order, ids 0..15 each returned exactly once, idle_out=1 at end.
